data_mem_lsu: RTL

Load/store initiator that drives the data-memory port on behalf of the core pipeline. It accepts one load or store request at a time over a valid/ready handshake and performs a single-cycle access on the memory's shared address port. It returns a registered response carrying read data or an out-of-range error. It sits between the execute/memory stage and the 8-word, 16-bit data memory. It owns all sequencing of `mem_write_en` and `mem_read`.

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_mem_lsu.sv | 112 +++++++++++
 2 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: definitions shared by the data memory and its load/store initiator.
//   lsu_state_t : initiator FSM state encoding (IDLE, ACCESS, RESP)
//   DMEM_DEPTH  : number of addressable data-memory words
//   DMEM_ADDR_W : word-address width on the request and memory ports
//   DMEM_DATA_W : data width
package data_mem_pkg;

  localparam int DMEM_DEPTH  = 8;
  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store initiator for the 8-word data memory.
// It takes one request at a time, performs a single-cycle access on the memory
// port, and returns a registered response with read data or a range error.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_wdata   request payload (1 = store, 0 = load)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            response payload
//   mem_access_addr, mem_write_data, mem_write_en, mem_read, mem_read_data
//                                 memory port (write commits on rising edge,
//                                 read data is combinational)
//   dbg_state                     current FSM state, for observation only
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload stable until that edge; a
// sink may raise or drop ready freely. Neither side may make valid wait on ready.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MEM_DEPTH = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output lsu_state_t        dbg_state
);

  lsu_state_t state;
  logic       in_range;

  // Full-width compare: high address bits never alias onto low words.
  assign in_range  = (req_addr < ADDR_W'(MEM_DEPTH));
  assign dbg_state = state;

  // The memory-side outputs are flops themselves; they hold the latched request
  // for exactly the ACCESS cycle, so the memory never sees request-input glitches,
  // and the asynchronous reset drops the strobes without waiting for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      mem_access_addr <= '0;
      mem_write_data  <= '0;
      mem_write_en    <= 1'b0;
      mem_read        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (in_range) begin
              state           <= ACCESS;
              mem_access_addr <= req_addr;
              mem_write_en    <= req_we;
              mem_read        <= ~req_we;
              mem_write_data  <= req_we ? req_wdata : '0;
            end else begin
              // Range error: skip the memory entirely and answer next cycle.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          state           <= RESP;
          rsp_valid       <= 1'b1;
          rsp_err         <= 1'b0;
          rsp_rdata       <= mem_read ? mem_read_data : '0;
          mem_access_addr <= '0;
          mem_write_data  <= '0;
          mem_write_en    <= 1'b0;
          mem_read        <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
